// File: rtl/shifter_seq_32_if.sv
// rtl/shifter_seq_32_if.sv - request/result bundle for the sequential 32-bit shifter
interface shifter_seq_32_if;
    logic        START;
    logic        SH_DIR;
    logic        SH_ROT;
    logic [4:0]  SH_AMT;
    logic [31:0] D_IN;
    logic [31:0] D_OUT;
    logic        BUSY;
    logic        DONE;

    // Controller side: issues requests, collects results.
    modport master (
        output START, SH_DIR, SH_ROT, SH_AMT, D_IN,
        input  D_OUT, BUSY, DONE
    );

    // Shifter side.
    modport slave (
        input  START, SH_DIR, SH_ROT, SH_AMT, D_IN,
        output D_OUT, BUSY, DONE
    );
endinterface

// File: rtl/shifter_seq_32.sv
// rtl/shifter_seq_32.sv - five-pass (16/8/4/2/1) sequential 32-bit shifter; rotate enabled by SHIFTER_ROTATE_EN
module shifter_seq_32 (
    input  logic             CLK,
    input  logic             RST_N,
    shifter_seq_32_if.slave  bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [31:0] work;
    logic [4:0]  amt;
    logic        dir;
    logic [4:0]  step;
    logic [31:0] stage_out;

`ifdef SHIFTER_ROTATE_EN
    logic        rot;
`else
    // SH_ROT is accepted but has no effect in the shift-only build.
    logic        unused_rot;
    assign unused_rot = bus.SH_ROT;
`endif

    // One binary-weighted pass: shift (or rotate) the working register by 2^idx when that amount bit is set.
    always_comb begin
        step      = 5'd1 << idx;
        stage_out = work;
        if (amt[idx]) begin
            // Right shift fills from bit 31 so the result matches an arithmetic shift of the operand.
            stage_out = dir ? $unsigned($signed(work) >>> step) : (work << step);
`ifdef SHIFTER_ROTATE_EN
            if (rot) begin
                stage_out = dir ? ((work >> step) | (work << (6'd32 - {1'b0, step})))
                                : ((work << step) | (work >> (6'd32 - {1'b0, step})));
            end
`endif
        end
    end

    // Control FSM: capture on START in IDLE, run all five passes, publish result with a one-cycle DONE.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            idx       <= 3'd0;
            work      <= 32'h0;
            amt       <= 5'd0;
            dir       <= 1'b0;
`ifdef SHIFTER_ROTATE_EN
            rot       <= 1'b0;
`endif
            bus.D_OUT <= 32'h0;
            bus.BUSY  <= 1'b0;
            bus.DONE  <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        work     <= bus.D_IN;
                        amt      <= bus.SH_AMT;
                        dir      <= bus.SH_DIR;
`ifdef SHIFTER_ROTATE_EN
                        rot      <= bus.SH_ROT;
`endif
                        idx      <= 3'd4;
                        bus.BUSY <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= stage_out;
                    if (idx == 3'd0) begin
                        bus.D_OUT <= stage_out;
                        bus.DONE  <= 1'b1;
                        bus.BUSY  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
